// File: rtl/sinegen_ctrl.sv
// Sample-rate controller for the sine-ROM / sigma-delta path: phase accumulator, tick divider,
// ROM fetch pipeline and valid/ready output register. Define SINEGEN_QUARTER_WAVE_EN for a quarter-period ROM.
module sinegen_ctrl #(
    parameter int SIZE    = 1024,
    parameter int BITLEN  = 16,
    parameter int PHASE_W = 24,
    parameter int DIV_W   = 16,
    parameter int OVR_W   = 8,
    localparam int ADDR_W = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [DIV_W-1:0]   rate_div,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               rom_re,
    input  logic [BITLEN-1:0]  rom_data,
    output logic [BITLEN-1:0]  sample_out,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               busy,
    output logic [OVR_W-1:0]   overrun_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               tick;
    logic               in_flight;
    logic [PHASE_W-1:0] phase_reg;
    logic [DIV_W-1:0]   cnt_reg;
    logic [ADDR_W-1:0]  addr_next;
    logic [ADDR_W-1:0]  rom_addr_reg;
    logic               rom_re_reg;
    logic               fetch_d1_reg;
    logic               in_vld;
    logic [BITLEN-1:0]  in_data;
    logic               load;
    logic [BITLEN-1:0]  sample_reg;
    logic               valid_reg;
    logic [OVR_W-1:0]   ovr_reg;

`ifdef SINEGEN_QUARTER_WAVE_EN
    logic [ADDR_W+1:0]  quarter;
    logic               neg_s1_reg;
    logic               neg_s2_reg;
    logic               stage_vld_reg;
    logic [BITLEN-1:0]  stage_data_reg;

    assign quarter = phase_reg[PHASE_W-1 -: ADDR_W+2];
    // Odd quadrants walk the table backwards; SIZE-1-idx is the bitwise complement for a power-of-two depth.
    assign addr_next = quarter[ADDR_W] ? ~quarter[ADDR_W-1:0] : quarter[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_s1_reg     <= 1'b0;
            neg_s2_reg     <= 1'b0;
            stage_vld_reg  <= 1'b0;
            stage_data_reg <= '0;
        end else begin
            if (tick) begin
                neg_s1_reg <= quarter[ADDR_W+1];
            end
            neg_s2_reg    <= neg_s1_reg;
            stage_vld_reg <= fetch_d1_reg;
            if (fetch_d1_reg) begin
                stage_data_reg <= neg_s2_reg ? -rom_data : rom_data;
            end
        end
    end

    assign in_vld    = stage_vld_reg;
    assign in_data   = stage_data_reg;
    assign in_flight = rom_re_reg | fetch_d1_reg | stage_vld_reg;
`else
    assign addr_next = phase_reg[PHASE_W-1 -: ADDR_W];
    assign in_vld    = fetch_d1_reg;
    assign in_data   = rom_data;
    assign in_flight = rom_re_reg | fetch_d1_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // DRAIN ignores enable and waits until the fetch pipeline is empty.
    always_comb begin
        state_next = state_reg;
        tick       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = DRAIN;
                end else if (cnt_reg == '0) begin
                    tick = 1'b1;
                end
            end
            DRAIN: begin
                if (!in_flight) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= '0;
            cnt_reg   <= '0;
        end else if (state_reg != RUN) begin
            phase_reg <= '0;
            cnt_reg   <= '0;
        end else if (tick) begin
            phase_reg <= phase_reg + phase_inc;
            cnt_reg   <= rate_div;
        end else if (enable) begin
            cnt_reg   <= cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_reg <= '0;
            rom_re_reg   <= 1'b0;
            fetch_d1_reg <= 1'b0;
        end else begin
            rom_re_reg   <= tick;
            fetch_d1_reg <= rom_re_reg;
            if (tick) begin
                rom_addr_reg <= addr_next;
            end
        end
    end

    // A new sample may replace the held one only in the cycle the modulator takes it.
    assign load = in_vld && (!valid_reg || sample_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_reg <= '0;
            valid_reg  <= 1'b0;
            ovr_reg    <= '0;
        end else begin
            if (load) begin
                sample_reg <= in_data;
                valid_reg  <= 1'b1;
            end else if (valid_reg && sample_ready) begin
                valid_reg  <= 1'b0;
            end
            if (in_vld && !load && (ovr_reg != {OVR_W{1'b1}})) begin
                ovr_reg <= ovr_reg + 1'b1;
            end
        end
    end

    assign rom_addr     = rom_addr_reg;
    assign rom_re       = rom_re_reg;
    assign sample_out   = sample_reg;
    assign sample_valid = valid_reg;
    assign overrun_cnt  = ovr_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_sinegen_ctrl.sv
// Scoreboard bench for sinegen_ctrl: stimulus pushes expected fetches/samples with arrival cycles,
// negedge monitors pop and compare. Honours SINEGEN_QUARTER_WAVE_EN when defined.
module tb_sinegen_ctrl;

    localparam int SIZE    = 1024;
    localparam int BITLEN  = 16;
    localparam int PHASE_W = 24;
    localparam int DIV_W   = 16;
    localparam int OVR_W   = 8;
    localparam int ADDR_W  = 10;
`ifdef SINEGEN_QUARTER_WAVE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic [PHASE_W-1:0] phase_inc;
    logic [DIV_W-1:0]   rate_div;
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_re;
    logic [BITLEN-1:0]  rom_data;
    logic [BITLEN-1:0]  sample_out;
    logic               sample_valid;
    logic               sample_ready;
    logic               busy;
    logic [OVR_W-1:0]   overrun_cnt;

    sinegen_ctrl #(
        .SIZE(SIZE), .BITLEN(BITLEN), .PHASE_W(PHASE_W), .DIV_W(DIV_W), .OVR_W(OVR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .phase_inc(phase_inc), .rate_div(rate_div),
        .rom_addr(rom_addr), .rom_re(rom_re), .rom_data(rom_data),
        .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .busy(busy), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [BITLEN-1:0] rom_mem [SIZE];
    always @(posedge clk) begin
        if (rom_re) rom_data <= rom_mem[rom_addr];
    end

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t addr_q[$];
    exp_t samp_q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   delivered = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: table position from the phase, quadrant folding when quarter-wave.
    function automatic int exp_addr(input logic [PHASE_W-1:0] ph);
`ifdef SINEGEN_QUARTER_WAVE_EN
        int pos = int'(ph >> (PHASE_W - ADDR_W - 2));
        int q   = pos / SIZE;
        int i   = pos % SIZE;
        return (q % 2 == 1) ? (SIZE - 1 - i) : i;
`else
        return int'(ph >> (PHASE_W - ADDR_W));
`endif
    endfunction

    function automatic int model_sample(input logic [PHASE_W-1:0] ph);
        logic [BITLEN-1:0] r;
        r = rom_mem[exp_addr(ph)];
`ifdef SINEGEN_QUARTER_WAVE_EN
        if (int'(ph >> (PHASE_W - 2)) >= 2) r = -r;
`endif
        return int'(r);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rom_re) begin
                if (addr_q.size() == 0) begin
                    check("unexpected_fetch", int'(rom_addr), -1);
                end else begin
                    e = addr_q.pop_front();
                    check("rom_addr", int'(rom_addr), e.val);
                    check("fetch_cycle", cyc, e.cyc);
                    $display("fetch  cyc=%0d addr=%0d", cyc, rom_addr);
                end
            end
            if (sample_valid && sample_ready) begin
                delivered++;
                if (samp_q.size() == 0) begin
                    check("unexpected_sample", int'(sample_out), -1);
                end else begin
                    e = samp_q.pop_front();
                    check("sample_out", int'(sample_out), e.val);
                    if (e.cyc >= 0) check("sample_cycle", cyc, e.cyc);
                    $display("sample cyc=%0d data=0x%04h", cyc, sample_out);
                end
            end
        end
    end

    // One enable burst of n ticks; drops=1 expects only the first sample to survive.
    task automatic run(input int n, input int rd, input logic [PHASE_W-1:0] inc,
                       input bit rnd, input bit drops);
        logic [PHASE_W-1:0] ph;
        int cur_rd;
        int steps;
        ph = '0;
        check("busy_idle", int'(busy), 0);
        enable    = 1'b1;
        rate_div  = DIV_W'(rd);
        phase_inc = inc;
        step();
        check("busy_rise", int'(busy), 1);
        for (int k = 0; k < n; k++) begin
            if (rnd && k > 0) begin
                phase_inc = PHASE_W'($urandom);
                rate_div  = DIV_W'($urandom_range(0, 4));
            end
            cur_rd = int'(rate_div);
            addr_q.push_back('{exp_addr(ph), cyc + 1});
            if (!drops || k == 0) samp_q.push_back('{model_sample(ph), drops ? -1 : cyc + LAT});
            ph = ph + phase_inc;
            if (k < n - 1) repeat (cur_rd + 1) step();
            else step();
        end
        enable = 1'b0;
        steps  = 0;
        while (busy && steps < 20) begin
            step();
            steps++;
        end
        check("busy_fall_delay", steps, LAT);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < SIZE; i++) begin
`ifdef SINEGEN_QUARTER_WAVE_EN
            rom_mem[i] = BITLEN'($urandom) & 16'h7FFF;
`else
            rom_mem[i] = BITLEN'($urandom);
`endif
        end
        rom_mem[0] = 16'h2A5B;

        rst_n = 1'b0; enable = 1'b0; phase_inc = '0; rate_div = '0; sample_ready = 1'b1;
        repeat (3) step();
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_rom_re", int'(rom_re), 0);
        check("rst_sample_out", int'(sample_out), 0);
        check("rst_sample_valid", int'(sample_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun_cnt), 0);
        rst_n = 1'b1;
        step();

        run(8, 3, 24'h004000, 1'b0, 1'b0);
        run(9, 0, 24'h400000, 1'b0, 1'b0);
        run(6, 0, 24'h100000, 1'b0, 1'b0);

        d0 = delivered;
        run(5, 0, PHASE_W'($urandom), 1'b0, 1'b0);
        check("delivered_after_drop", delivered - d0, 5);

        for (int r = 0; r < 5; r++) begin
            run($urandom_range(3, 12), $urandom_range(0, 5), PHASE_W'($urandom), 1'b1, 1'b0);
        end

        sample_ready = 1'b0;
        run(10, 0, PHASE_W'($urandom), 1'b0, 1'b1);
        check("held_sample", int'(sample_out), int'(rom_mem[0]));
        check("held_valid", int'(sample_valid), 1);
        check("overrun_cnt", int'(overrun_cnt), 9);
        sample_ready = 1'b1;
        step();
        check("valid_cleared", int'(sample_valid), 0);

        enable = 1'b1; rate_div = '0; phase_inc = 24'h004000;
        step();
        addr_q.push_back('{0, cyc + 1});
        step();
        addr_q.push_back('{1, cyc + 1});
        step();
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        check("arst_rom_addr", int'(rom_addr), 0);
        check("arst_rom_re", int'(rom_re), 0);
        check("arst_sample_valid", int'(sample_valid), 0);
        check("arst_sample_out", int'(sample_out), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_overrun", int'(overrun_cnt), 0);
        addr_q.delete();
        samp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_valid", int'(sample_valid), 0);
        end

        run(4, 1, 24'h004000, 1'b0, 1'b0);
        repeat (3) step();
        check("addr_q_empty", addr_q.size(), 0);
        check("samp_q_empty", samp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
